// File: rtl/srv_mem_pkg.sv
// Shared FSM state encoding and default geometry for the line-fill memory server.
// Pure type/constant package; no logic.
package srv_mem_pkg;

    localparam int DEF_N_CH      = 2;
    localparam int DEF_LINE_W    = 128;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_AWIDTH    = 10;
    localparam int DEF_MEM_DELAY = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_e;

    // Counter widths must never collapse to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/srv_line_mem_if.sv
// Requester + backing-store bundle for srv_line_mem.
// slave = the memory server, master = requesters/ROM side.
interface srv_line_mem_if #(
    parameter int N_CH   = srv_mem_pkg::DEF_N_CH,
    parameter int LINE_W = srv_mem_pkg::DEF_LINE_W,
    parameter int WORD_W = srv_mem_pkg::DEF_WORD_W
);
    logic [N_CH-1:0]       req_i;
    logic [N_CH-1:0][31:0] addr_i;
    logic [N_CH-1:0]       rsp_o;
    logic [LINE_W-1:0]     data_o;
    logic                  busy_o;
    logic [31:0]           rom_addr_o;
    logic [WORD_W-1:0]     rom_data_i;

    modport slave (
        input  req_i, addr_i, rom_data_i,
        output rsp_o, data_o, busy_o, rom_addr_o
    );

    modport master (
        output req_i, addr_i, rom_data_i,
        input  rsp_o, data_o, busy_o, rom_addr_o
    );
endinterface

// File: rtl/srv_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority starts after the last granted channel.
// Latency: combinational grant; pointer updates on the cycle advance is high.
// Backpressure: none; requests are simply not granted while advance stays low.
module srv_rr_arb
    import srv_mem_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [N_CH-1:0] grant
);

    localparam int CHW = clog2_min1(N_CH);

    logic [CHW-1:0] last_q;
    logic [CHW-1:0] gnt_idx;

    always_comb begin
        int   idx;
        logic found;
        grant   = '0;
        gnt_idx = last_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_q) + i) % N_CH;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = CHW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Reset pointer at the last channel so ch0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CHW'(N_CH - 1);
        end else if (advance && (|req)) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/srv_line_mem.sv
// Line-fill server: arbitrates requesters, reads WORDS backing-store words, answers with a full line.
// Latency: rsp exactly MEM_DELAY cycles after the grant; grants spaced MEM_DELAY+1 cycles apart.
// Backpressure: requests held until rsp; new requests only sampled in IDLE, rsp cannot be stalled.
module srv_line_mem
    import srv_mem_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int LINE_W    = DEF_LINE_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int MEM_DELAY = DEF_MEM_DELAY
) (
    input  logic          clk,
    input  logic          rst_n,
    srv_line_mem_if.slave bus
);

    localparam int WORDS = LINE_W / WORD_W;
    localparam int OFFW  = (WORDS > 1) ? $clog2(WORDS) : 0;
    localparam int WCW   = clog2_min1(WORDS);
    localparam int DCW   = clog2_min1(MEM_DELAY + 1);
    localparam int CHW   = clog2_min1(N_CH);
    localparam logic [AWIDTH-1:0] ALIGN_MASK = {AWIDTH{1'b1}} << OFFW;

    generate
        if ((LINE_W % WORD_W) != 0) begin : g_bad_line
            $error("srv_line_mem: LINE_W must be a multiple of WORD_W");
        end
        if ((WORDS & (WORDS - 1)) != 0) begin : g_bad_words
            $error("srv_line_mem: LINE_W/WORD_W must be a power of two");
        end
        if (MEM_DELAY < WORDS + 1) begin : g_bad_delay
            $error("srv_line_mem: MEM_DELAY must be >= WORDS+1");
        end
        if (AWIDTH > 32) begin : g_bad_awidth
            $error("srv_line_mem: AWIDTH must not exceed 32");
        end
    endgenerate

    mem_state_e        state_q, state_d;
    logic [N_CH-1:0]   grant;
    logic [CHW-1:0]    sel_idx;
    logic [CHW-1:0]    gnt_idx_q;
    logic [AWIDTH-1:0] base_q;
    logic [AWIDTH-1:0] fetch_addr;
    logic [WCW-1:0]    wcnt_q;
    logic [DCW-1:0]    dly_q;
    logic [LINE_W-1:0] data_q;
    logic              start;
    logic              last_word;
    logic              dly_last;

    assign start     = (state_q == ST_IDLE) && (|bus.req_i);
    assign last_word = (wcnt_q == WCW'(WORDS - 1));
    assign dly_last  = (dly_q == DCW'(MEM_DELAY - 1));

    srv_rr_arb #(
        .N_CH (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_i),
        .advance (start),
        .grant   (grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) sel_idx = CHW'(i);
        end
    end

    // Next-state: dly_q equals the cycle offset from the grant, so RESP lands on G+MEM_DELAY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (last_word) state_d = dly_last ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (dly_last) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            gnt_idx_q <= '0;
            wcnt_q    <= '0;
            dly_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q    <= bus.addr_i[sel_idx][AWIDTH-1:0] & ALIGN_MASK;
                        gnt_idx_q <= sel_idx;
                        wcnt_q    <= '0;
                        dly_q     <= DCW'(1);
                    end
                end
                ST_FETCH: begin
                    wcnt_q <= last_word ? '0 : wcnt_q + WCW'(1);
                    dly_q  <= dly_q + DCW'(1);
                end
                ST_WAIT: dly_q <= dly_q + DCW'(1);
                default: dly_q <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (state_q == ST_FETCH) begin
            for (int w = 0; w < WORDS; w++) begin
                if (wcnt_q == WCW'(w)) data_q[w*WORD_W +: WORD_W] <= bus.rom_data_i;
            end
        end
    end

    // Truncating add keeps the fetch inside the AWIDTH address space.
    assign fetch_addr     = base_q + AWIDTH'(wcnt_q);
    assign bus.rom_addr_o = (state_q == ST_FETCH) ? 32'(fetch_addr) : 32'd0;
    assign bus.busy_o     = (state_q != ST_IDLE);
    assign bus.data_o     = data_q;

    always_comb begin
        bus.rsp_o = '0;
        if (state_q == ST_RESP) bus.rsp_o[gnt_idx_q] = 1'b1;
    end

endmodule

// File: tb/tb_srv_line_mem.sv
// Directed bench for srv_line_mem: default geometry DUT plus a 256-bit line / MEM_DELAY=9 DUT.
// Backing store returns 0x5A5A0000 | addr[15:0] combinationally.
module tb_srv_line_mem;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    srv_line_mem_if #(.N_CH(2), .LINE_W(128), .WORD_W(32)) bus0 ();
    srv_line_mem_if #(.N_CH(2), .LINE_W(256), .WORD_W(32)) bus1 ();

    srv_line_mem #(
        .N_CH(2), .LINE_W(128), .WORD_W(32), .AWIDTH(10), .MEM_DELAY(10)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    srv_line_mem #(
        .N_CH(2), .LINE_W(256), .WORD_W(32), .AWIDTH(10), .MEM_DELAY(9)
    ) u_wide (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h5A5A0000 | {16'h0000, a[15:0]};
    endfunction

    assign bus0.rom_data_i = rom_word(bus0.rom_addr_o);
    assign bus1.rom_data_i = rom_word(bus1.rom_addr_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus0.req_i   = 2'b00;
        bus0.addr_i  = '0;
        bus1.req_i   = 2'b00;
        bus1.addr_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus0.busy_o); end
        checks++; if (bus0.rsp_o !== 2'b00) begin errors++; $display("FAIL reset rsp: got %b expected 00", bus0.rsp_o); end
        checks++; if (bus0.rom_addr_o !== 32'h0) begin errors++; $display("FAIL reset rom_addr: got %h expected 0", bus0.rom_addr_o); end
        checks++; if (bus0.data_o !== 128'h0) begin errors++; $display("FAIL reset data: got %h expected 0", bus0.data_o); end
        checks++; if (bus1.busy_o !== 1'b0 || bus1.data_o !== 256'h0) begin errors++; $display("FAIL reset wide: got busy %b data %h expected 0/0", bus1.busy_o, bus1.data_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_fill();
        logic [31:0] exp_addr;
        logic [1:0]  exp_rsp;
        logic        exp_busy;
        bus0.addr_i[0] = 32'h13;
        bus0.addr_i[1] = 32'h2A0;
        bus0.req_i     = 2'b01;
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL single busy cycle 0: got %b expected 0", bus0.busy_o); end
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) bus0.addr_i[0] = 32'h200;
            if (c == 5) bus0.addr_i[1] = 32'h155;
            exp_addr = (c <= 4) ? 32'h10 + 32'(c - 1) : 32'h0;
            exp_rsp  = (c == 10) ? 2'b01 : 2'b00;
            exp_busy = (c <= 10);
            checks++; if (bus0.rom_addr_o !== exp_addr) begin errors++; $display("FAIL single rom_addr cycle %0d: got %h expected %h", c, bus0.rom_addr_o, exp_addr); end
            checks++; if (bus0.rsp_o !== exp_rsp) begin errors++; $display("FAIL single rsp cycle %0d: got %b expected %b", c, bus0.rsp_o, exp_rsp); end
            checks++; if (bus0.busy_o !== exp_busy) begin errors++; $display("FAIL single busy cycle %0d: got %b expected %b", c, bus0.busy_o, exp_busy); end
            if (c == 10) begin
                checks++; if (bus0.data_o !== 128'h5A5A0013_5A5A0012_5A5A0011_5A5A0010) begin errors++; $display("FAIL single data: got %h expected 5a5a00135a5a00125a5a00115a5a0010", bus0.data_o); end
                bus0.req_i = 2'b00;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        logic [1:0]  exp_rsp;
        bus0.addr_i[1] = 32'hFFFF_FFFE;
        bus0.req_i     = 2'b10;
        checks++; if (bus0.data_o !== 128'h5A5A0013_5A5A0012_5A5A0011_5A5A0010) begin errors++; $display("FAIL wrap hold data: got %h expected previous line", bus0.data_o); end
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 3) bus0.req_i = 2'b00;
            exp_addr = (c <= 4) ? 32'h3FC + 32'(c - 1) : 32'h0;
            exp_rsp  = (c == 10) ? 2'b10 : 2'b00;
            checks++; if (bus0.rom_addr_o !== exp_addr) begin errors++; $display("FAIL wrap rom_addr cycle %0d: got %h expected %h", c, bus0.rom_addr_o, exp_addr); end
            checks++; if (bus0.rsp_o !== exp_rsp) begin errors++; $display("FAIL wrap rsp cycle %0d: got %b expected %b", c, bus0.rsp_o, exp_rsp); end
        end
        checks++; if (bus0.data_o !== 128'h5A5A03FF_5A5A03FE_5A5A03FD_5A5A03FC) begin errors++; $display("FAIL wrap data: got %h expected 5a5a03ff5a5a03fe5a5a03fd5a5a03fc", bus0.data_o); end
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL wrap idle busy: got %b expected 0", bus0.busy_o); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_rsp;
        logic [31:0] exp_addr;
        bus0.addr_i[0] = 32'h20;
        bus0.addr_i[1] = 32'h40;
        bus0.req_i     = 2'b11;
        for (int c = 1; c <= 33; c++) begin
            tick();
            exp_rsp = (c == 10 || c == 32) ? 2'b01 : (c == 21) ? 2'b10 : 2'b00;
            checks++; if (bus0.rsp_o !== exp_rsp) begin errors++; $display("FAIL contention rsp cycle %0d: got %b expected %b", c, bus0.rsp_o, exp_rsp); end
            if (c == 1 || c == 12 || c == 23) begin
                exp_addr = (c == 12) ? 32'h40 : 32'h20;
                checks++; if (bus0.rom_addr_o !== exp_addr) begin errors++; $display("FAIL contention rom_addr cycle %0d: got %h expected %h", c, bus0.rom_addr_o, exp_addr); end
            end
            if (c == 10 || c == 32) begin
                checks++; if (bus0.data_o !== 128'h5A5A0023_5A5A0022_5A5A0021_5A5A0020) begin errors++; $display("FAIL contention data ch0 cycle %0d: got %h expected line 0x20", c, bus0.data_o); end
            end
            if (c == 21) begin
                checks++; if (bus0.data_o !== 128'h5A5A0043_5A5A0042_5A5A0041_5A5A0040) begin errors++; $display("FAIL contention data ch1: got %h expected line 0x40", bus0.data_o); end
            end
            if (c == 32) bus0.req_i = 2'b00;
        end
        checks++; if (bus0.busy_o !== 1'b0) begin errors++; $display("FAIL contention idle busy: got %b expected 0", bus0.busy_o); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_rsp;
        bus0.addr_i[0] = 32'h30;
        bus0.req_i     = 2'b01;
        repeat (6) tick();
        checks++; if (bus0.busy_o !== 1'b1) begin errors++; $display("FAIL midreset busy before: got %b expected 1", bus0.busy_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.busy_o !== 1'b0 || bus0.rsp_o !== 2'b00) begin errors++; $display("FAIL midreset state: got busy %b rsp %b expected 0/00", bus0.busy_o, bus0.rsp_o); end
        checks++; if (bus0.data_o !== 128'h0) begin errors++; $display("FAIL midreset data: got %h expected 0", bus0.data_o); end
        bus0.addr_i[0] = 32'h50;
        bus0.addr_i[1] = 32'h60;
        bus0.req_i     = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus0.busy_o !== 1'b0 || bus0.rsp_o !== 2'b00) begin errors++; $display("FAIL midreset held: got busy %b rsp %b expected 0/00", bus0.busy_o, bus0.rsp_o); end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            exp_rsp = (c == 10) ? 2'b01 : 2'b00;
            checks++; if (bus0.rsp_o !== exp_rsp) begin errors++; $display("FAIL midreset rsp cycle %0d: got %b expected %b", c, bus0.rsp_o, exp_rsp); end
            if (c == 1) begin
                checks++; if (bus0.rom_addr_o !== 32'h50) begin errors++; $display("FAIL midreset regrant rom_addr: got %h expected 00000050", bus0.rom_addr_o); end
            end
            if (c == 10) begin
                checks++; if (bus0.data_o !== 128'h5A5A0053_5A5A0052_5A5A0051_5A5A0050) begin errors++; $display("FAIL midreset data: got %h expected line 0x50", bus0.data_o); end
                bus0.req_i = 2'b00;
            end
        end
    endtask

    task automatic test_wide();
        logic [31:0] exp_addr;
        logic [1:0]  exp_rsp;
        logic        exp_busy;
        bus1.addr_i[1] = 32'h105;
        bus1.req_i     = 2'b10;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_addr = (c <= 8) ? 32'h100 + 32'(c - 1) : 32'h0;
            exp_rsp  = (c == 9) ? 2'b10 : 2'b00;
            exp_busy = (c <= 9);
            checks++; if (bus1.rom_addr_o !== exp_addr) begin errors++; $display("FAIL wide rom_addr cycle %0d: got %h expected %h", c, bus1.rom_addr_o, exp_addr); end
            checks++; if (bus1.rsp_o !== exp_rsp) begin errors++; $display("FAIL wide rsp cycle %0d: got %b expected %b", c, bus1.rsp_o, exp_rsp); end
            checks++; if (bus1.busy_o !== exp_busy) begin errors++; $display("FAIL wide busy cycle %0d: got %b expected %b", c, bus1.busy_o, exp_busy); end
            if (c == 9) begin
                checks++; if (bus1.data_o !== 256'h5A5A0107_5A5A0106_5A5A0105_5A5A0104_5A5A0103_5A5A0102_5A5A0101_5A5A0100) begin errors++; $display("FAIL wide data: got %h expected line 0x100", bus1.data_o); end
                bus1.req_i = 2'b00;
            end
        end
        checks++; if (bus0.rsp_o !== 2'b00 || bus0.busy_o !== 1'b0) begin errors++; $display("FAIL wide narrow idle: got rsp %b busy %b expected 00/0", bus0.rsp_o, bus0.busy_o); end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_wrap();
        test_contention();
        test_reset_mid();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
